// File: rtl/motor_hbridge_sequencer_if.sv
// Request/bridge bundle between motion-control logic and the H-bridge sequencer.
// Channel k occupies hb[2k+1:2k] as {A_hi, A_lo}.
interface motor_hbridge_sequencer_if #(
    parameter int N_MOTORS = 2
);
    logic [N_MOTORS-1:0]   run;
    logic [N_MOTORS-1:0]   dir;
    logic                  estop;
    logic [2*N_MOTORS-1:0] hb;
    logic [N_MOTORS-1:0]   busy;
    logic [N_MOTORS-1:0]   driving;

    modport master (
        output run, dir, estop,
        input  hb, busy, driving
    );

    modport slave (
        input  run, dir, estop,
        output hb, busy, driving
    );
endinterface

// File: rtl/motor_hbridge_sequencer.sv
// Per-channel H-bridge sequencer: every drive change passes through an all-off
// dead interval so the high and low legs of a bridge never switch together.
module motor_hbridge_sequencer #(
    parameter int N_MOTORS    = 2,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    motor_hbridge_sequencer_if.slave    bus
);
    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (DEAD_CYCLES < 1) begin : g_bad_dead
            $error("motor_hbridge_sequencer: DEAD_CYCLES must be at least 1");
        end
        if (N_MOTORS < 1) begin : g_bad_n
            $error("motor_hbridge_sequencer: N_MOTORS must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < N_MOTORS; gi++) begin : g_ch
            state_t           r_state;
            state_t           w_state_next;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic             w_req_fwd;
            logic             w_req_rev;
            logic [1:0]       r_hb;
            logic             r_busy;
            logic             r_driving;

            // Estop masks the request, so every state sees it as a stop.
            assign w_req_fwd = !bus.estop && bus.run[gi] &&  bus.dir[gi];
            assign w_req_rev = !bus.estop && bus.run[gi] && !bus.dir[gi];

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                case (r_state)
                    ST_IDLE: begin
                        if (w_req_fwd)      w_state_next = ST_FWD;
                        else if (w_req_rev) w_state_next = ST_REV;
                    end
                    ST_FWD: begin
                        if (!w_req_fwd) begin
                            w_state_next = ST_DEAD;
                            w_cnt_next   = CNT_LOAD;
                        end
                    end
                    ST_REV: begin
                        if (!w_req_rev) begin
                            w_state_next = ST_DEAD;
                            w_cnt_next   = CNT_LOAD;
                        end
                    end
                    ST_DEAD: begin
                        if (bus.estop) begin
                            w_cnt_next = CNT_LOAD;
                        end else if (r_cnt != '0) begin
                            w_cnt_next = r_cnt - CNT_ONE;
                        end else if (w_req_fwd) begin
                            w_state_next = ST_FWD;
                        end else if (w_req_rev) begin
                            w_state_next = ST_REV;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            // Outputs are registered from the next state so they track r_state exactly.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state   <= ST_IDLE;
                    r_cnt     <= '0;
                    r_hb      <= 2'b00;
                    r_busy    <= 1'b0;
                    r_driving <= 1'b0;
                end else begin
                    r_state   <= w_state_next;
                    r_cnt     <= w_cnt_next;
                    r_hb      <= (w_state_next == ST_FWD) ? 2'b10 :
                                 (w_state_next == ST_REV) ? 2'b01 : 2'b00;
                    r_busy    <= (w_state_next == ST_DEAD);
                    r_driving <= (w_state_next == ST_FWD) || (w_state_next == ST_REV);
                end
            end

            assign bus.hb[2*gi +: 2] = r_hb;
            assign bus.busy[gi]      = r_busy;
            assign bus.driving[gi]   = r_driving;
        end
    endgenerate
endmodule

// File: tb/tb_motor_hbridge_sequencer.sv
// Directed and randomized checks of the H-bridge sequencer against a
// deadline-based model of the dead-time rules.
module tb_motor_hbridge_sequencer;
    localparam int N = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    motor_hbridge_sequencer_if #(.N_MOTORS(N)) bus ();

    motor_hbridge_sequencer #(.N_MOTORS(N), .DEAD_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: drive mode 0=off 1=fwd 2=rev, plus an absolute edge index at which
    // an active dead interval ends.
    int cyc = 0;
    int m_mode [N];
    bit m_dead [N];
    int m_end  [N];
    logic [2*N-1:0] prev_hb = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        int req;
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (reset) begin
                m_mode[k] = 0;
                m_dead[k] = 1'b0;
                m_end[k]  = 0;
            end else begin
                req = (bus.estop || !bus.run[k]) ? 0 : (bus.dir[k] ? 1 : 2);
                if (m_dead[k]) begin
                    if (bus.estop) m_end[k] = cyc + D;
                    else if (cyc >= m_end[k]) begin
                        m_dead[k] = 1'b0;
                        m_mode[k] = req;
                    end
                end else if (m_mode[k] == 0) begin
                    m_mode[k] = req;
                end else if (req != m_mode[k]) begin
                    m_mode[k] = 0;
                    m_dead[k] = 1'b1;
                    m_end[k]  = cyc + D;
                end
            end
        end
    endtask

    task automatic tick();
        logic [1:0] e_hb, o_hb, p_hb;
        @(posedge clk);
        model_edge();
        #1;
        $display("cyc %0d rst=%b run=%b dir=%b estop=%b hb=%b busy=%b drv=%b",
                 cyc, reset, bus.run, bus.dir, bus.estop, bus.hb, bus.busy, bus.driving);
        for (int k = 0; k < N; k++) begin
            e_hb = (m_mode[k] == 1) ? 2'b10 : (m_mode[k] == 2) ? 2'b01 : 2'b00;
            o_hb = bus.hb[2*k +: 2];
            p_hb = prev_hb[2*k +: 2];
            chk($sformatf("hb%0d", k), 32'(o_hb), 32'(e_hb));
            chk($sformatf("busy%0d", k), 32'(bus.busy[k]), 32'(m_dead[k]));
            chk($sformatf("driving%0d", k), 32'(bus.driving[k]), 32'(m_mode[k] != 0));
            chk($sformatf("never11_%0d", k), 32'(o_hb == 2'b11), 32'd0);
            chk($sformatf("noflip%0d", k),
                32'((p_hb == 2'b10 && o_hb == 2'b01) || (p_hb == 2'b01 && o_hb == 2'b10)), 32'd0);
        end
        prev_hb = bus.hb;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            m_mode[k] = 0;
            m_dead[k] = 1'b0;
            m_end[k]  = 0;
        end
        reset     = 1'b1;
        bus.run   = 2'b11;
        bus.dir   = 2'b11;
        bus.estop = 1'b0;

        // Reset held with drive requested: outputs stay off
        ticks(3);
        chk("rst_hb", 32'(bus.hb), 32'h0);
        reset = 1'b0;
        tick();
        chk("rel_hb", 32'(bus.hb), 32'b1010);
        chk("rel_drv", 32'(bus.driving), 32'b11);
        chk("rel_busy", 32'(bus.busy), 32'b00);

        // Ch0 reverses: four dead cycles, ch1 untouched
        bus.dir = 2'b10;
        tick();
        chk("rev_enter", 32'(bus.hb), 32'b1000);
        chk("rev_busy", 32'(bus.busy), 32'b01);
        ticks(3);
        chk("rev_last_dead", 32'(bus.hb), 32'b1000);
        tick();
        chk("rev_exit", 32'(bus.hb), 32'b1001);

        // Ch0 stop then restart from idle without dead time
        bus.run = 2'b10;
        ticks(D + 2);
        chk("stop_idle", 32'(bus.hb[1:0]), 32'b00);
        chk("stop_busy", 32'(bus.busy[0]), 32'b0);
        bus.run = 2'b11;
        bus.dir = 2'b11;
        tick();
        chk("restart", 32'(bus.hb), 32'b1010);

        // Estop pulse of three cycles
        bus.estop = 1'b1;
        tick();
        chk("estop_off", 32'(bus.hb), 32'h0);
        ticks(2);
        bus.estop = 1'b0;
        ticks(D + 3);
        chk("estop_resume", 32'(bus.hb), 32'b1010);

        // Toggle dir during dead time; exit follows the final request
        bus.dir[0] = 1'b0;
        tick();
        for (int i = 0; i < D; i++) begin
            bus.dir[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            if (i == D - 1) bus.dir[0] = 1'b1;
            tick();
        end
        chk("toggle_exit", 32'(bus.hb[1:0]), 32'b10);
        ticks(2);

        // Reset in the middle of dead time and while driving
        bus.dir = 2'b10;
        ticks(2);
        reset = 1'b1;
        tick();
        chk("rst_mid_hb", 32'(bus.hb), 32'h0);
        chk("rst_mid_busy", 32'(bus.busy), 32'h0);
        chk("rst_mid_drv", 32'(bus.driving), 32'h0);
        reset = 1'b0;
        ticks(3);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) bus.run[k] = ~bus.run[k];
                if ($urandom_range(0, 5) == 0) bus.dir[k] = ~bus.dir[k];
            end
            if (bus.estop) bus.estop = ($urandom_range(0, 2) != 0);
            else           bus.estop = ($urandom_range(0, 60) == 0);
            reset = ($urandom_range(0, 250) == 0);
            tick();
        end
        reset = 1'b0;
        bus.estop = 1'b0;
        ticks(D + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
